// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell is reused over WIDTH cycles, LSB first,
// with the running carry kept in a flip-flop and a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNTW-1:0] LastCnt = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] MsbCnt  = CNTW'(WIDTH - 2);

    state_e           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic             carry_q;
    logic             c_msb_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;

    logic cell_s;
    logic cell_c;

    // The shared full-adder cell.
    assign cell_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign cell_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            psum_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : carryin;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    psum_q  <= {cell_s, psum_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= cell_c;
                    cnt_q   <= cnt_q + 1'b1;
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (cnt_q == MsbCnt) begin
                        c_msb_q <= cell_c;
                    end
                    if (cnt_q == LastCnt) begin
                        sum      <= {cell_s, psum_q[WIDTH-1:1]};
                        carryout <= cell_c;
                        overflow <= c_msb_q ^ cell_c;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed handshake/reset cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         sub;
    logic         carryin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carryout;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] e_sum;
    logic         e_co;
    logic         e_ov;

    serial_adder_ctrl #(.WIDTH(W), .CNTW(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout),
        .overflow (overflow)
    );

    always #200 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: ordinary modular arithmetic; signed overflow from operand/result signs.
    task automatic model(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                         input logic osub);
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb    = osub ? ~ob : ob;
        full  = {1'b0, oa} + {1'b0, bb} + ((osub ? 1'b1 : ocin) ? 1 : 0);
        e_sum = full[W-1:0];
        e_co  = full[W];
        e_ov  = (oa[W-1] == bb[W-1]) && (e_sum[W-1] != oa[W-1]);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                            input logic osub);
        model(oa, ob, ocin, osub);
        a       = oa;
        b       = ob;
        carryin = ocin;
        sub     = osub;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        a       = W'($urandom);
        b       = W'($urandom);
        carryin = 1'($urandom);
        sub     = 1'($urandom);
    endtask

    // Expects exactly W busy cycles, then the done cycle with model results.
    task automatic wait_run(input int inject, input logic [W-1:0] ia, input logic [W-1:0] ib);
        for (int i = 0; i < int'(W); i++) begin
            start = 1'b0;
            chk("busy_in_run", 32'(busy), 32'd1);
            chk("done_in_run", 32'(done), 32'd0);
            if (i == inject) begin
                start = 1'b1;
                a     = ia;
                b     = ib;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("sum", 32'(sum), 32'(e_sum));
        chk("carryout", 32'(carryout), 32'(e_co));
        chk("overflow", 32'(overflow), 32'(e_ov));
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        sub     = 1'b0;
        carryin = 1'b0;
        a       = '0;
        b       = '0;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_co", 32'(carryout), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Plain add with signed overflow, then done must drop and results hold.
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_run(-1, '0, '0);
        chk("sum_5a3c", 32'(sum), 32'h96);
        chk("ov_5a3c", 32'(overflow), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd0);
            chk("hold_busy", 32'(busy), 32'd0);
        end
        chk("hold_sum", 32'(sum), 32'h96);
        chk("hold_co", 32'(carryout), 32'd0);
        chk("hold_ov", 32'(overflow), 32'd1);

        // Wrap cases and subtraction (carryin ignored when sub=1).
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_run(-1, '0, '0);
        chk("sum_ff01", 32'(sum), 32'h00);
        @(negedge clk);
        start_op(8'h7F, 8'h00, 1'b1, 1'b0);
        wait_run(-1, '0, '0);
        chk("sum_7f00c", 32'(sum), 32'h80);
        @(negedge clk);
        start_op(8'h10, 8'h20, 1'b1, 1'b1);
        wait_run(-1, '0, '0);
        chk("sum_sub1020", 32'(sum), 32'hF0);
        @(negedge clk);
        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        wait_run(-1, '0, '0);
        chk("ov_sub8001", 32'(overflow), 32'd1);
        @(negedge clk);

        // Start during RUN ignored; start in DONE accepted back-to-back.
        start_op(8'h01, 8'h01, 1'b0, 1'b0);
        wait_run(3, 8'hAA, 8'h55);
        chk("sum_ignore", 32'(sum), 32'h02);
        start_op(8'h03, 8'h04, 1'b0, 1'b0);
        wait_run(-1, '0, '0);
        chk("sum_b2b", 32'(sum), 32'h07);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        start_op(8'hF0, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_pre_rst", 32'(busy), 32'd1);
            @(negedge clk);
        end
        #50 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_co", 32'(carryout), 32'd0);
        chk("arst_ov", 32'(overflow), 32'd0);
        @(negedge clk);
        chk("arst_done2", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        start_op(8'h01, 8'h02, 1'b0, 1'b0);
        wait_run(-1, '0, '0);
        chk("sum_post_rst", 32'(sum), 32'h03);

        // Random operations, alternating back-to-back and idle-separated starts.
        for (int n = 0; n < 24; n++) begin
            if (n % 3 == 0) @(negedge clk);
            start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            wait_run(-1, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
